// File: rtl/vga_pkg.sv
// Shared VGA timing description: the timing record, the stock 640x480@60 mode
// and a helper that sizes a whole frame in pixel clocks.
package vga_pkg;

    typedef struct packed {
        int unsigned h_active;
        int unsigned h_fp;
        int unsigned h_sync;
        int unsigned h_bp;
        int unsigned v_active;
        int unsigned v_fp;
        int unsigned v_sync;
        int unsigned v_bp;
    } vga_timing_t;

    localparam vga_timing_t VGA_640X480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33
    };

    // Pixel clocks per complete frame (line length times line count).
    function automatic int unsigned total(vga_timing_t t);
        return (t.h_active + t.h_fp + t.h_sync + t.h_bp) *
               (t.v_active + t.v_fp + t.v_sync + t.v_bp);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: a wrapping position counter plus active/sync region decode.
// Used for both the pixel (horizontal) and line (vertical) axes.
module vga_axis_counter #(
    parameter int unsigned ACTIVE = 4,
    parameter int unsigned FP     = 1,
    parameter int unsigned SYNC   = 1,
    parameter int unsigned BP     = 1,
    localparam int unsigned TOTAL = ACTIVE + FP + SYNC + BP,
    localparam int W              = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt,
    output logic         wrap,
    output logic         active,
    output logic         sync_region
);

    // Every boundary is below TOTAL (BP >= 1), so all fit in W bits.
    localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_HI = W'(ACTIVE + FP + SYNC);

    assign wrap        = inc && (cnt == LAST);
    assign active      = (cnt < ACT_END);
    assign sync_region = (cnt >= SYNC_LO) && (cnt < SYNC_HI);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc)
            cnt <= wrap ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: two axis counters feeding one register stage of
// sync, data-enable, coordinate and line/frame pulse outputs.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = VGA_640X480_60.h_active,
    parameter int unsigned H_FP      = VGA_640X480_60.h_fp,
    parameter int unsigned H_SYNC    = VGA_640X480_60.h_sync,
    parameter int unsigned H_BP      = VGA_640X480_60.h_bp,
    parameter int unsigned V_ACTIVE  = VGA_640X480_60.v_active,
    parameter int unsigned V_FP      = VGA_640X480_60.v_fp,
    parameter int unsigned V_SYNC    = VGA_640X480_60.v_sync,
    parameter int unsigned V_BP      = VGA_640X480_60.v_bp,
    parameter int unsigned HSYNC_POL = 0,
    parameter int unsigned VSYNC_POL = 0,
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int HW                = $clog2(H_TOTAL),
    localparam int VW                = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    output logic          hsync,
    output logic          vsync,
    output logic          de,
    output logic [HW-1:0] pixel_x,
    output logic [VW-1:0] pixel_y,
    output logic          line_start,
    output logic          frame_start
);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
        $error("vga_timing_gen: every timing parameter must be non-zero");
    end
    if (HSYNC_POL > 1 || VSYNC_POL > 1) begin : g_bad_pol
        $error("vga_timing_gen: sync polarity parameters must be 0 or 1");
    end

    localparam logic HS_ON = HSYNC_POL[0];
    localparam logic VS_ON = VSYNC_POL[0];

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_wrap, h_act, h_sync_rgn;
    logic          v_wrap, v_act, v_sync_rgn;
    logic          frame_head;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk         (clk),
        .rst         (rst),
        .inc         (en),
        .cnt         (h_cnt),
        .wrap        (h_wrap),
        .active      (h_act),
        .sync_region (h_sync_rgn)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk         (clk),
        .rst         (rst),
        .inc         (h_wrap),
        .cnt         (v_cnt),
        .wrap        (v_wrap),
        .active      (v_act),
        .sync_region (v_sync_rgn)
    );

    // frame_head is high exactly while the counters sit at (0,0); tracking it
    // from the wraps avoids a full-width compare of both counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixel_x     <= '0;
            pixel_y     <= '0;
            de          <= 1'b0;
            hsync       <= ~HS_ON;
            vsync       <= ~VS_ON;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_head  <= 1'b1;
        end else if (en) begin
            pixel_x     <= h_cnt;
            pixel_y     <= v_cnt;
            de          <= h_act && v_act;
            hsync       <= h_sync_rgn ? HS_ON : ~HS_ON;
            vsync       <= v_sync_rgn ? VS_ON : ~VS_ON;
            line_start  <= (h_cnt == '0);
            frame_start <= frame_head;
            frame_head  <= h_wrap && v_wrap;
        end else begin
            // Stalled cycle: position and levels hold, pulses must not repeat.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default mode line timing, a medium
// mode for frame/reset/random-stall behaviour and a tiny mode for exact tables.
module tb_vga_timing_gen;

    typedef struct {
        int   ha, hf, hsw, hb;
        int   va, vf, vsw, vb;
        logic hp, vp;
    } tim_t;

    typedef struct packed {
        int   x;
        int   y;
        logic de, hs, vs, ls, fs;
    } obs_t;

    typedef struct {
        logic rst;
        logic en;
        obs_t want;
    } vec_t;

    logic clk;
    int   checks, failures;

    // A: default 640x480@60
    logic       rst_a, en_a, hs_a, vs_a, de_a, ls_a, fs_a;
    logic [9:0] x_a;
    logic [9:0] y_a;
    // B: 64/4/8/4 x 48/3/2/5, active-low syncs (80 x 58 = 4640 clocks per frame)
    logic       rst_b, en_b, hs_b, vs_b, de_b, ls_b, fs_b;
    logic [6:0] x_b;
    logic [5:0] y_b;
    // C: 4/1/1/1 x 2/1/1/1, active-high syncs (7 x 5 = 35 clocks per frame)
    logic       rst_c, en_c, hs_c, vs_c, de_c, ls_c, fs_c;
    logic [2:0] x_c;
    logic [2:0] y_c;

    vga_timing_gen u_a (
        .clk(clk), .rst(rst_a), .en(en_a), .hsync(hs_a), .vsync(vs_a), .de(de_a),
        .pixel_x(x_a), .pixel_y(y_a), .line_start(ls_a), .frame_start(fs_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(48), .V_FP(3), .V_SYNC(2), .V_BP(5),
        .HSYNC_POL(0), .VSYNC_POL(0)
    ) u_b (
        .clk(clk), .rst(rst_b), .en(en_b), .hsync(hs_b), .vsync(vs_b), .de(de_b),
        .pixel_x(x_b), .pixel_y(y_b), .line_start(ls_b), .frame_start(fs_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HSYNC_POL(1), .VSYNC_POL(1)
    ) u_c (
        .clk(clk), .rst(rst_c), .en(en_c), .hsync(hs_c), .vsync(vs_c), .de(de_c),
        .pixel_x(x_c), .pixel_y(y_c), .line_start(ls_c), .frame_start(fs_c)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    // Position k (0-based count of advancing cycles) mapped straight onto the raster.
    function automatic obs_t ref_pos(tim_t t, int k);
        obs_t r;
        int   ht, vt;
        ht   = t.ha + t.hf + t.hsw + t.hb;
        vt   = t.va + t.vf + t.vsw + t.vb;
        r.x  = k % ht;
        r.y  = (k / ht) % vt;
        r.de = (r.x < t.ha) && (r.y < t.va);
        r.hs = (r.x >= t.ha + t.hf && r.x < t.ha + t.hf + t.hsw) ? t.hp : ~t.hp;
        r.vs = (r.y >= t.va + t.vf && r.y < t.va + t.vf + t.vsw) ? t.vp : ~t.vp;
        r.ls = (r.x == 0);
        r.fs = (r.x == 0) && (r.y == 0);
        return r;
    endfunction

    function automatic obs_t oa();
        return '{int'(x_a), int'(y_a), de_a, hs_a, vs_a, ls_a, fs_a};
    endfunction
    function automatic obs_t ob();
        return '{int'(x_b), int'(y_b), de_b, hs_b, vs_b, ls_b, fs_b};
    endfunction
    function automatic obs_t oc();
        return '{int'(x_c), int'(y_c), de_c, hs_c, vs_c, ls_c, fs_c};
    endfunction

    task automatic chk(input string name, input obs_t got, input obs_t want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b, expected x=%0d y=%0d de=%0b hs=%0b vs=%0b ls=%0b fs=%0b",
                     name, got.x, got.y, got.de, got.hs, got.vs, got.ls, got.fs,
                     want.x, want.y, want.de, want.hs, want.vs, want.ls, want.fs);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    tim_t ta, tb;
    vec_t tbl[$];
    obs_t rst_lo, rst_hi, held, want;
    logic ls_s[2400], hs_s[2400], de_s[2400];
    int   x_s[2400];
    int   ls_pos[$], fs_pos[$];
    int   k, vs_in, vs_out, de_bad, found;

    initial begin
        checks   = 0;
        failures = 0;
        ta = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
        tb = '{64, 4, 8, 4, 48, 3, 2, 5, 1'b0, 1'b0};
        rst_lo = '{0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};  // reset look, active-high syncs
        rst_hi = '{0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};  // reset look, active-low syncs

        // Tiny-mode table: reset, rst-over-en, one full 35-clock frame, wrap, stalls.
        tbl.push_back('{1'b1, 1'b0, rst_lo});
        tbl.push_back('{1'b1, 1'b1, rst_lo});
        for (int i = 0; i < 35; i++) begin
            int x, y;
            x = i % 7;
            y = i / 7;
            tbl.push_back('{1'b0, 1'b1, '{x, y, (x < 4 && y < 2), (x == 5), (y == 3), (x == 0), (i == 0)}});
        end
        tbl.push_back('{1'b0, 1'b1, '{0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}});
        tbl.push_back('{1'b0, 1'b0, '{0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{1'b0, 1'b0, '{0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{1'b0, 1'b1, '{1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}});
        tbl.push_back('{1'b1, 1'b1, rst_lo});
        tbl.push_back('{1'b0, 1'b1, '{0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1}});

        rst_a = 1'b1; en_a = 1'b0;
        rst_b = 1'b1; en_b = 1'b0;
        rst_c = 1'b1; en_c = 1'b0;
        repeat (3) step();
        chk("a_reset", oa(), rst_hi);
        chk("b_reset", ob(), rst_hi);

        foreach (tbl[i]) begin
            rst_c = tbl[i].rst;
            en_c  = tbl[i].en;
            step();
            chk($sformatf("c_vec%0d", i), oc(), tbl[i].want);
        end
        en_c = 1'b0;

        // Default mode: three lines continuous.
        rst_a = 1'b0;
        en_a  = 1'b1;
        for (int i = 0; i < 2400; i++) begin
            step();
            ls_s[i] = ls_a; hs_s[i] = hs_a; de_s[i] = de_a; x_s[i] = int'(x_a);
            if (ls_a) ls_pos.push_back(i);
            chk($sformatf("a_pos%0d", i), oa(), ref_pos(ta, i));
        end
        en_a = 1'b0;
        chk_int("a_line_start_count", ls_pos.size(), 3);
        if (ls_pos.size() == 3) begin
            chk_int("a_line_period0", ls_pos[1] - ls_pos[0], 800);
            chk_int("a_line_period1", ls_pos[2] - ls_pos[1], 800);
        end
        for (int l = 0; l < 3; l++) begin
            int nlow, first, nde;
            nlow = 0; first = -1; nde = 0;
            for (int i = l * 800; i < l * 800 + 800; i++) begin
                if (!hs_s[i]) begin
                    nlow++;
                    if (first < 0) first = i;
                end
                if (de_s[i]) nde++;
            end
            chk_int($sformatf("a_hs_low_clocks_line%0d", l), nlow, 96);
            chk_int($sformatf("a_hs_start_x_line%0d", l), (first < 0) ? -1 : x_s[first], 656);
            chk_int($sformatf("a_de_clocks_line%0d", l), nde, 640);
        end

        // Medium mode: one full frame plus the first cycle of the next.
        rst_b = 1'b0;
        en_b  = 1'b1;
        vs_in = 0; vs_out = 0; de_bad = 0;
        for (int i = 0; i <= 4640; i++) begin
            step();
            if (fs_b) fs_pos.push_back(i);
            if (i < 4640) begin
                if (!vs_b && (y_b == 51 || y_b == 52)) vs_in++;
                if (!vs_b && !(y_b == 51 || y_b == 52)) vs_out++;
                if (de_b && y_b >= 48) de_bad++;
            end
            chk($sformatf("b_pos%0d", i), ob(), ref_pos(tb, i));
        end
        chk_int("b_frame_start_count", fs_pos.size(), 2);
        if (fs_pos.size() == 2) chk_int("b_frame_period", fs_pos[1] - fs_pos[0], 4640);
        chk_int("b_vs_low_on_sync_lines", vs_in, 160);
        chk_int("b_vs_low_elsewhere", vs_out, 0);
        chk_int("b_de_in_vblank", de_bad, 0);

        // Run to (30,20), then reset mid-frame.
        found = 0;
        for (int n = 0; n < 5000; n++) begin
            if (x_b == 30 && y_b == 20) begin
                found = 1;
                break;
            end
            step();
        end
        chk_int("b_reached_30_20", found, 1);
        rst_b = 1'b1;
        en_b  = 1'b0;
        step();
        chk("b_mid_reset", ob(), rst_hi);
        en_b = 1'b1;
        repeat (2) begin
            step();
            chk("b_rst_beats_en", ob(), rst_hi);
        end
        rst_b = 1'b0;
        step();
        chk("b_restart_origin", ob(), ref_pos(tb, 0));

        // Random stalls over two frames against the continuous-run reference.
        k    = 1;
        held = ref_pos(tb, 0);
        for (int n = 0; n < 40000 && k <= 2 * 4640; n++) begin
            en_b = ($urandom % 4) != 0;
            step();
            if (en_b) begin
                want = ref_pos(tb, k);
                k++;
            end else begin
                want    = held;
                want.ls = 1'b0;
                want.fs = 1'b0;
            end
            held = want;
            chk($sformatf("b_rand_k%0d_en%0b", k, en_b), ob(), want);
        end
        en_b = 1'b0;
        chk_int("b_random_two_frames_done", (k > 2 * 4640) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Generates VGA raster timing from the pixel clock: horizontal and vertical counters, hsync, vsync, data-enable and pixel coordinates.
- Sits directly downstream of the pixel-clock source. Its outputs feed the pixel/colour pipeline and the DAC/pin stage.
- Timing is fully parameterised. Defaults are 640x480@60 (25.175 MHz nominal; the bench drives a 40 ns period).

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BP, 48, horizontal back porch (clocks)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of vsync

Derived values:
- H_TOTAL = sum of the four H_* parameters; V_TOTAL = sum of the four V_* parameters.
- HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
- clk  input  1  pixel clock
- rst  input  1  synchronous active-high reset
- en  input  1  advance enable; when low, all state and outputs hold
- hsync  output  1  horizontal sync, polarity set by HSYNC_POL
- vsync  output  1  vertical sync, polarity set by VSYNC_POL
- de  output  1  high while the output position lies in the active area
- pixel_x  output  HW  horizontal position of the current output cycle
- pixel_y  output  VW  vertical position of the current output cycle
- line_start  output  1  one-cycle pulse when pixel_x == 0
- frame_start  output  1  one-cycle pulse when pixel_x == 0 and pixel_y == 0

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high. No asynchronous logic.
- Reset values:
  - h_cnt = 0, v_cnt = 0.
  - pixel_x = 0, pixel_y = 0.
  - de = 0, line_start = 0, frame_start = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
- Counters:
  - On a cycle with en=1, h_cnt increments and wraps from H_TOTAL-1 to 0.
  - v_cnt increments only when h_cnt wraps, and itself wraps from V_TOTAL-1 to 0.
- Outputs:
  - Every output is registered from the pre-increment (h_cnt, v_cnt) on each en=1 cycle. Latency is therefore exactly 1 clock, and all outputs are mutually aligned.
  - First en=1 cycle after reset: the following cycle shows pixel_x=0, pixel_y=0, de=1, line_start=1, frame_start=1.
- Region decode (x = pixel_x, y = pixel_y):
  - de = (x < H_ACTIVE) && (y < V_ACTIVE).
  - hsync asserted for H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
  - vsync asserted for V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC, on whole lines. It changes together with pixel_y, i.e. when x returns to 0.
- en=0:
  - Counters and all output registers hold.
  - Pulses (line_start, frame_start) are forced to 0 during hold, so a stalled cycle never repeats a pulse.
  - Resuming continues from the held position.
- Reset mid-frame: next cycle returns to the reset values; the raster restarts at (0,0) on the next en=1 cycle.
- Reset has priority over en.
- Widths and arithmetic:
  - Comparisons are unsigned, against constants computed at elaboration.
  - Elaboration $error if any parameter is 0, or if a polarity parameter is not 0 or 1.

Decomposition:
- vga_pkg holds:
  - typedef vga_timing_t: struct of the eight timing fields.
  - localparam VGA_640X480_60 of type vga_timing_t.
  - function total(vga_timing_t).
- Sub-module vga_axis_counter, instantiated twice (horizontal, vertical):
  - Parameters ACTIVE, FP, SYNC, BP.
  - Inputs: inc.
  - Outputs: cnt, wrap, active, sync_region.
  - vga_timing_gen adds the output registers, polarity handling and pulses.

Test Plan:
- Default params, rst 3 cycles then en=1 constant: line_start period = 800 clocks; hsync low for exactly 96 clocks starting at pixel_x=656; de high exactly 640 clocks per active line.
- Same run over a full frame: frame_start period = 420000 clocks; vsync low exactly on pixel_y=490..491 (1600 clocks); de never high for pixel_y>=480.
- Small params (H 4/1/1/1, V 2/1/1/1, both polarities 1): frame = 35 clocks; check the exact 35-cycle sequence of pixel_x, pixel_y, de, hsync (high at x=5), vsync (high on y=3).
- en toggled randomly over 2 frames: outputs hold on en=0; pulses never repeat during hold; the sequence over en=1 cycles is identical to the continuous-run reference.
- rst asserted at pixel_x=300, pixel_y=200: next cycle shows reset values; the first en=1 cycle after release yields (0,0), frame_start=1.
- rst and en high together: rst wins, and the outputs stay at their reset values.
